ss2_bus_arbiter: RTL and testbench



---
 rtl/ss2_bus_arbiter_pkg.sv | 17 +
 rtl/ss2_rr_pick2.sv | 16 +
 rtl/ss2_bus_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_ss2_bus_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ss2_bus_arbiter_pkg.sv
// rtl/ss2_bus_arbiter_pkg.sv - shared state encoding and counter sizing for the register bus arbiter
package ss2_bus_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_ACK    = 3'd4
  } state_e;

  // The phase counter holds cycles-1, so max_cycles-1 must fit; never narrower than one bit.
  function automatic int cnt_width(input int max_cycles);
    return (max_cycles < 2) ? 1 : $clog2(max_cycles);
  endfunction

endpackage

// File: rtl/ss2_rr_pick2.sv
// rtl/ss2_rr_pick2.sv - combinational two-way round-robin picker
module ss2_rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant,
  output logic       valid
);

  always_comb begin
    valid = |req;
    // Under contention the master that was not served last wins.
    if (&req) grant = ~last;
    else      grant = req[1];
  end

endmodule

// File: rtl/ss2_bus_arbiter.sv
// rtl/ss2_bus_arbiter.sv - two-master arbiter and cen/rdn/wrn strobe sequencer for the target register bus
module ss2_bus_arbiter
  import ss2_bus_arbiter_pkg::*;
#(
  parameter int pADDR_WIDTH    = 32,
  parameter int pDATA_WIDTH    = 8,
  parameter int pSETUP_CYCLES  = 1,
  parameter int pSTROBE_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   m0_req,
  input  logic                   m0_we,
  input  logic [pADDR_WIDTH-1:0] m0_addr,
  input  logic [pDATA_WIDTH-1:0] m0_wdata,
  output logic                   m0_ack,
  output logic [pDATA_WIDTH-1:0] m0_rdata,
  input  logic                   m1_req,
  input  logic                   m1_we,
  input  logic [pADDR_WIDTH-1:0] m1_addr,
  input  logic [pDATA_WIDTH-1:0] m1_wdata,
  output logic                   m1_ack,
  output logic [pDATA_WIDTH-1:0] m1_rdata,
  output logic [pADDR_WIDTH-1:0] bus_addr,
  output logic [pDATA_WIDTH-1:0] bus_wdata,
  input  logic [pDATA_WIDTH-1:0] bus_rdata,
  output logic                   bus_cen,
  output logic                   bus_rdn,
  output logic                   bus_wrn,
  output logic                   busy
);

  localparam int MAX_CYC = (pSETUP_CYCLES > pSTROBE_CYCLES) ? pSETUP_CYCLES : pSTROBE_CYCLES;
  localparam int CNT_W   = cnt_width(MAX_CYC);
  localparam logic [CNT_W-1:0] SETUP_LOAD  = CNT_W'(pSETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(pSTROBE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  generate
    if (pSETUP_CYCLES < 1 || pSTROBE_CYCLES < 1) begin : g_bad_cfg
      $fatal(1, "ss2_bus_arbiter: pSETUP_CYCLES and pSTROBE_CYCLES must both be >= 1");
    end
  endgenerate

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     last_q, last_d;
  logic                     win_q, win_d;
  logic                     we_q, we_d;
  logic [pADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [pDATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [pDATA_WIDTH-1:0]   cap_q, cap_d;
  logic [pDATA_WIDTH-1:0]   rd0_q, rd0_d;
  logic [pDATA_WIDTH-1:0]   rd1_q, rd1_d;
  logic                     ack0_q, ack0_d;
  logic                     ack1_q, ack1_d;
  logic                     cen_q, cen_d;
  logic                     rdn_q, rdn_d;
  logic                     wrn_q, wrn_d;
  logic                     busy_q, busy_d;
  logic                     pick_grant, pick_valid;

  ss2_rr_pick2 u_pick (
    .req   ({m1_req, m0_req}),
    .last  (last_q),
    .grant (pick_grant),
    .valid (pick_valid)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    win_d   = win_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cap_d   = cap_q;
    rd0_d   = rd0_q;
    rd1_d   = rd1_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          win_d   = pick_grant;
          we_d    = pick_grant ? m1_we    : m0_we;
          addr_d  = pick_grant ? m1_addr  : m0_addr;
          wdata_d = pick_grant ? m1_wdata : m0_wdata;
          state_d = ST_SETUP;
          cnt_d   = SETUP_LOAD;
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d = ST_STROBE;
          cnt_d   = STROBE_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_STROBE: begin
        if (cnt_q == '0) begin
          // Edge closing the last strobe cycle: target data is settled here.
          cap_d   = bus_rdata;
          state_d = ST_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_HOLD: begin
        state_d = ST_ACK;
        cnt_d   = '0;
        last_d  = win_q;
        if (win_q) ack1_d = 1'b1;
        else       ack0_d = 1'b1;
        if (!we_q) begin
          if (win_q) rd1_d = cap_q;
          else       rd0_d = cap_q;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Strobes are decoded from the next state so they leave the flops glitch-free.
    cen_d  = !(state_d == ST_SETUP || state_d == ST_STROBE || state_d == ST_HOLD);
    rdn_d  = !(state_d == ST_STROBE && !we_d);
    wrn_d  = !(state_d == ST_STROBE && we_d);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      win_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cap_q   <= '0;
      rd0_q   <= '0;
      rd1_q   <= '0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      cen_q   <= 1'b1;
      rdn_q   <= 1'b1;
      wrn_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      win_q   <= win_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cap_q   <= cap_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      cen_q   <= cen_d;
      rdn_q   <= rdn_d;
      wrn_q   <= wrn_d;
      busy_q  <= busy_d;
    end
  end

  assign m0_ack    = ack0_q;
  assign m1_ack    = ack1_q;
  assign m0_rdata  = rd0_q;
  assign m1_rdata  = rd1_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign bus_cen   = cen_q;
  assign bus_rdn   = rdn_q;
  assign bus_wrn   = wrn_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_ss2_bus_arbiter.sv
// tb/tb_ss2_bus_arbiter.sv - randomized self-checking bench for ss2_bus_arbiter
module tb_ss2_bus_arbiter;
  localparam int AW = 32;
  localparam int DW = 8;
  localparam int S  = 1;
  localparam int T  = 2;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic          m0_req = 0, m1_req = 0, m0_we = 0, m1_we = 0;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0;
  logic [DW-1:0] m0_wdata = '0, m1_wdata = '0, bus_rdata = '0;
  logic          m0_ack, m1_ack, bus_cen, bus_rdn, bus_wrn, busy;
  logic [DW-1:0] m0_rdata, m1_rdata, bus_wdata;
  logic [AW-1:0] bus_addr;

  logic          b_req = 0, b_we = 0;
  logic [AW-1:0] b_addr = '0;
  logic [DW-1:0] b_wdata = '0;
  logic          b_ack, b_m1_ack, b_cen, b_rdn, b_wrn, b_busy;
  logic [DW-1:0] b_rdata, b_m1_rdata, b_bus_wdata;
  logic [AW-1:0] b_bus_addr;

  ss2_bus_arbiter #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .pSETUP_CYCLES(S), .pSTROBE_CYCLES(T)) dut (
    .clk(clk), .resetn(resetn),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_cen(bus_cen), .bus_rdn(bus_rdn), .bus_wrn(bus_wrn), .busy(busy)
  );

  ss2_bus_arbiter #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .pSETUP_CYCLES(3), .pSTROBE_CYCLES(1)) dut2 (
    .clk(clk), .resetn(resetn),
    .m0_req(b_req), .m0_we(b_we), .m0_addr(b_addr), .m0_wdata(b_wdata), .m0_ack(b_ack), .m0_rdata(b_rdata),
    .m1_req(1'b0), .m1_we(1'b0), .m1_addr('0), .m1_wdata('0), .m1_ack(b_m1_ack), .m1_rdata(b_m1_rdata),
    .bus_addr(b_bus_addr), .bus_wdata(b_bus_wdata), .bus_rdata(8'h00),
    .bus_cen(b_cen), .bus_rdn(b_rdn), .bus_wrn(b_wrn), .busy(b_busy)
  );

  int checks = 0;
  int errors = 0;

  // Transaction-level reference: one active transfer, timeline measured in edges since the grant.
  bit            mb, mwin, mwe, mlast;
  int            mt;
  logic [AW-1:0] maddr;
  logic [DW-1:0] mwd, mcap;
  logic [DW-1:0] mrd [2];
  bit            e_ack0, e_ack1;
  logic [DW-1:0] tmem [16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mb = 0; mt = 0; mlast = 1; mwin = 0; mwe = 0;
    maddr = '0; mwd = '0; mcap = '0;
    mrd[0] = '0; mrd[1] = '0;
    e_ack0 = 0; e_ack1 = 0;
  endtask

  task automatic model_step();
    if (mb) begin
      mt++;
      if (mt == S + T) mcap = bus_rdata;
      if (mt == S + T + 1) begin
        if (!mwe) mrd[mwin] = mcap;
        mlast = mwin;
      end
      if (mt == S + T + 2) mb = 0;
    end else if (m0_req || m1_req) begin
      mwin  = (m0_req && m1_req) ? !mlast : m1_req;
      mwe   = mwin ? m1_we : m0_we;
      maddr = mwin ? m1_addr : m0_addr;
      mwd   = mwin ? m1_wdata : m0_wdata;
      mb = 1;
      mt = 0;
    end
  endtask

  task automatic compare();
    bit in_cyc, in_str;
    in_cyc = mb && (mt <= S + T);
    in_str = mb && (mt >= S) && (mt < S + T);
    e_ack0 = mb && (mt == S + T + 1) && !mwin;
    e_ack1 = mb && (mt == S + T + 1) && mwin;
    chk("bus_cen", bus_cen, !in_cyc);
    chk("bus_rdn", bus_rdn, !(in_str && !mwe));
    chk("bus_wrn", bus_wrn, !(in_str && mwe));
    chk("m0_ack", m0_ack, e_ack0);
    chk("m1_ack", m1_ack, e_ack1);
    chk("busy", busy, mb);
    chk("bus_addr", bus_addr, maddr);
    chk("bus_wdata", bus_wdata, mwd);
    chk("m0_rdata", m0_rdata, mrd[0]);
    chk("m1_rdata", m1_rdata, mrd[1]);
  endtask

  task automatic cyc();
    @(posedge clk);
    if (!resetn) model_reset();
    else model_step();
    if (!bus_wrn) tmem[bus_addr[3:0]] = bus_wdata;
    @(negedge clk);
    compare();
  endtask

  task automatic master_update(input bit rnd);
    if (e_ack0) m0_req = 0;
    if (e_ack1) m1_req = 0;
    if (rnd) begin
      bus_rdata = DW'($urandom);
      if (!m0_req && $urandom_range(0, 2) == 0) begin
        m0_req = 1; m0_we = 1'($urandom_range(0, 1)); m0_addr = $urandom; m0_wdata = DW'($urandom);
      end
      if (!m1_req && $urandom_range(0, 2) == 0) begin
        m1_req = 1; m1_we = 1'($urandom_range(0, 1)); m1_addr = $urandom; m1_wdata = DW'($urandom);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cen_cnt, wrn_cnt, rdn_cnt, wrn_first, ack_idx, ack0_idx, ack1_idx, nack, n0, n1;
    logic [5:0] order;
    for (int i = 0; i < 16; i++) tmem[i] = '0;
    model_reset();

    // Reset state
    @(negedge clk); @(negedge clk);
    chk("rst_strobes", {bus_cen, bus_rdn, bus_wrn}, 3'b111);
    chk("rst_addr", bus_addr, 0);
    chk("rst_wdata", bus_wdata, 0);
    chk("rst_acks", {m0_ack, m1_ack}, 2'b00);
    chk("rst_rdata", {m0_rdata, m1_rdata}, 16'h0000);
    chk("rst_busy", busy, 0);
    resetn = 1;
    cyc();

    // m0 write 0xA5 to 0x4
    m0_req = 1; m0_we = 1; m0_addr = 32'h4; m0_wdata = 8'hA5;
    cen_cnt = 0; wrn_cnt = 0; wrn_first = 0; ack_idx = 0;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      if (!bus_cen) cen_cnt++;
      if (!bus_wrn) begin wrn_cnt++; if (wrn_first == 0) wrn_first = i; end
      if (m0_ack) ack_idx = i;
      master_update(0);
    end
    chk("wr_cen_cycles", cen_cnt, 4);
    chk("wr_wrn_cycles", wrn_cnt, 2);
    chk("wr_wrn_first", wrn_first, 2);
    chk("wr_ack_cycle", ack_idx, 5);
    chk("wr_target_reg", tmem[4], 8'hA5);

    // m1 read 0x10 returning 0x3C
    m1_req = 1; m1_we = 0; m1_addr = 32'h10; bus_rdata = 8'h3C;
    rdn_cnt = 0;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      if (!bus_rdn) rdn_cnt++;
      master_update(0);
    end
    chk("rd_rdn_cycles", rdn_cnt, 2);
    chk("rd_m1_rdata", m1_rdata, 8'h3C);
    chk("rd_m0_rdata", m0_rdata, 8'h00);

    // Simultaneous requests, three transactions each
    m0_req = 1; m0_we = 1; m0_addr = 32'h20; m0_wdata = 8'h11;
    m1_req = 1; m1_we = 0; m1_addr = 32'h30;
    n0 = 0; n1 = 0; nack = 0; order = '0;
    for (int i = 1; i <= 60 && nack < 6; i++) begin
      cyc();
      if (m0_ack) begin order = {order[4:0], 1'b0}; nack++; end
      if (m1_ack) begin order = {order[4:0], 1'b1}; nack++; end
      if (e_ack0) n0++;
      if (e_ack1) n1++;
      master_update(0);
      if (e_ack0 && n0 < 3) begin m0_req = 1; m0_wdata = m0_wdata + 8'h1; end
      if (e_ack1 && n1 < 3) begin m1_req = 1; m1_addr = m1_addr + 32'h1; end
    end
    chk("rr_ack_count", nack, 6);
    chk("rr_order", order, 6'b010101);
    for (int i = 0; i < 3; i++) begin cyc(); master_update(0); end

    // m1 arrives during m0 STROBE
    m0_req = 1; m0_we = 0; m0_addr = 32'h8; bus_rdata = 8'h5E;
    ack0_idx = 0; ack1_idx = 0;
    for (int i = 1; i <= 16; i++) begin
      cyc();
      if (m0_ack) ack0_idx = i;
      if (m1_ack) ack1_idx = i;
      master_update(0);
      if (i == 2) begin m1_req = 1; m1_we = 1; m1_addr = 32'h9; m1_wdata = 8'h77; end
    end
    chk("late_m0_ack", ack0_idx, 5);
    chk("late_gap", ack1_idx - ack0_idx, 6);
    chk("late_m0_rdata", m0_rdata, 8'h5E);

    // Reset pulse during the strobe of a write
    m0_req = 1; m0_we = 1; m0_addr = 32'h3; m0_wdata = 8'hC3;
    cyc(); master_update(0);
    cyc(); master_update(0);
    chk("pre_rst_wrn", bus_wrn, 0);
    #1 resetn = 0;
    #1;
    chk("async_strobes", {bus_cen, bus_rdn, bus_wrn}, 3'b111);
    chk("async_busy", busy, 0);
    chk("async_ack", {m0_ack, m1_ack}, 2'b00);
    m0_req = 0;
    cyc();
    resetn = 1;
    cyc(); master_update(0);
    m0_req = 1; m0_we = 0; m0_addr = 32'h1;
    m1_req = 1; m1_we = 0; m1_addr = 32'h2;
    ack_idx = 0;
    for (int i = 1; i <= 14; i++) begin
      cyc();
      if (m0_ack && ack_idx == 0) ack_idx = i;
      if (m1_ack && ack_idx == 0) ack_idx = 100 + i;
      master_update(0);
    end
    chk("post_rst_first_win", ack_idx, 5);

    // Randomized traffic against the reference
    for (int i = 0; i < 500; i++) begin
      cyc();
      master_update(1);
    end
    m0_req = 0; m1_req = 0;
    for (int i = 0; i < 8; i++) begin cyc(); master_update(0); end

    // Alternate timing build: 3 setup cycles, 1 strobe cycle
    b_req = 1; b_we = 1; b_addr = 32'h6; b_wdata = 8'h5A;
    cen_cnt = 0; wrn_cnt = 0; ack_idx = 0;
    for (int i = 1; i <= 10; i++) begin
      cyc();
      if (!b_cen) cen_cnt++;
      if (!b_wrn) wrn_cnt++;
      if (b_ack) begin ack_idx = i; b_req = 0; end
      master_update(0);
    end
    chk("p31_cen_cycles", cen_cnt, 5);
    chk("p31_wrn_cycles", wrn_cnt, 1);
    chk("p31_ack_cycle", ack_idx, 6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
